// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with stall/done handshake and dump-and-halt streaming
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en, wr, dump               request strobes from the decoder (load/store, store select, dump)
//   addr, wdata                byte address and store data
//   rdata                      registered load result, held until the next load completes
//   stall, done, err           pipeline hold, completion pulse, unaligned-access pulse
//   dump_valid/ready/addr/data valid/ready stream of the whole array during a dump
//   halted                     set once the dump has drained, until reset
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr,
    input  logic        dump,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_addr,
    output logic [15:0] dump_data,
    output logic        halted
);
    typedef enum logic [2:0] {IDLE, BUSY, RESP, DUMP, HALT} state_t;
    state_t state, state_nx;
    logic [15:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx, ptr;
    logic [3:0] cnt;
    logic wr_q;
    logic [15:0] wdata_q;
    logic start, commit;
    logic unused_addr;
    // address bits above the word index only alias
    assign unused_addr = ^addr[15:ADDR_W+1];
    assign start = en && !dump && !addr[0];
    assign commit = state == BUSY && cnt == 4'd0;
    assign dump_addr = dump_valid ? 16'({ptr, 1'b0}) : 16'd0;
    assign dump_data = dump_valid ? mem[ptr] : 16'd0;
    always_comb begin
        state_nx = state;
        stall = 1'b0;
        done = 1'b0;
        err = 1'b0;
        dump_valid = 1'b0;
        halted = 1'b0;
        case (state)
            IDLE: begin
                if (dump) begin
                    stall = 1'b1;
                    state_nx = DUMP;
                end else if (en && addr[0]) begin
                    err = 1'b1;
                    done = 1'b1;
                end else if (en) begin
                    stall = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                state_nx = cnt == 4'd0 ? RESP : BUSY;
            end
            RESP: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            DUMP: begin
                stall = 1'b1;
                dump_valid = 1'b1;
                state_nx = dump_ready && &ptr ? HALT : DUMP;
            end
            default: begin
                stall = 1'b1;
                halted = 1'b1;
            end
        endcase
        // IDLE decodes en combinationally, so keep outputs quiet while reset is held
        if (!rst_n) {stall, done, err} = 3'b000;
    end
    always_ff @(posedge clk) begin
        if (commit && wr_q) mem[idx] <= wdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdata <= 16'd0;
            idx <= '0;
            ptr <= '0;
            cnt <= 4'd0;
            wr_q <= 1'b0;
            wdata_q <= 16'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && dump) ptr <= '0;
            if (state == IDLE && start) begin
                wr_q <= wr;
                wdata_q <= wdata;
                idx <= addr[ADDR_W:1];
                cnt <= 4'(LATENCY - 1);
            end
            if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (commit && !wr_q) rdata <= mem[idx];
            if (dump_valid && dump_ready) ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table, random-vs-model and hand-written corner checks for dmem_responder
module tb_dmem_responder;
    localparam int LAT = 2;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, wr = 1'b0, dump = 1'b0, dump_ready = 1'b0;
    logic [15:0] addr = 16'd0, wdata = 16'd0;
    logic [15:0] rdata, dump_addr, dump_data;
    logic stall, done, err, dump_valid, halted;
    int checks = 0, errors = 0;
    logic [15:0] model [4];
    logic [15:0] last_rd;
    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        int          lat;
        logic        e;
        logic [15:0] rd;
    } vec_t;
    vec_t tbl [10];
    logic [15:0] exp_dump [4];
    logic [5:0] ready_pat;

    dmem_responder #(.ADDR_W(2), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .dump(dump), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .done(done), .err(err), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " stall"}, 16'(stall), 16'd0);
        chk({tag, " done"}, 16'(done), 16'd0);
        chk({tag, " err"}, 16'(err), 16'd0);
        chk({tag, " dump_valid"}, 16'(dump_valid), 16'd0);
        chk({tag, " halted"}, 16'(halted), 16'd0);
        chk({tag, " rdata"}, rdata, 16'd0);
        chk({tag, " dump_addr"}, dump_addr, 16'd0);
        chk({tag, " dump_data"}, dump_data, 16'd0);
    endtask

    // starts at posedge+1, returns at posedge+1 after the done cycle with en dropped
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic e, output logic [15:0] rd,
                          output logic st_ok, output logic st_done);
        en = 1'b1; wr = w; addr = a; wdata = d;
        lat = -1; e = 1'b0; rd = 16'hxxxx; st_ok = 1'b1; st_done = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #4;
            if (done) begin
                lat = n; e = err; rd = rdata; st_done = stall;
                break;
            end
            if (!stall) st_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                             input int exp_lat, input logic exp_e, input logic [15:0] exp_rd);
        int lat;
        logic e, st_ok, st_done;
        logic [15:0] rd;
        access(w, a, d, lat, e, rd, st_ok, st_done);
        chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
        chk({tag, " err"}, 16'(e), 16'(exp_e));
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " stall before done"}, 16'(st_ok), 16'd1);
        chk({tag, " stall at done"}, 16'(st_done), 16'd0);
    endtask

    // reference: aligned accesses take LAT+1 cycles on word (a/2) mod 4, odd addresses error at once
    task automatic model_access(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d);
        int k;
        logic e;
        e = (a % 2) == 1;
        k = (int'(a) / 2) % 4;
        if (!e) begin
            if (w) model[k] = d;
            else last_rd = model[k];
        end
        run_check(tag, w, a, d, e ? 0 : LAT + 1, e, last_rd);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, LAT + 1, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'h0010, 16'h0000, LAT + 1, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b0, 16'h0011, 16'h0000, 0,       1'b1, 16'hBEEF};
        tbl[3] = '{1'b1, 16'h0002, 16'h1234, LAT + 1, 1'b0, 16'hBEEF};
        tbl[4] = '{1'b0, 16'h0202, 16'h0000, LAT + 1, 1'b0, 16'h1234};
        tbl[5] = '{1'b1, 16'h7FFE, 16'h0F0F, LAT + 1, 1'b0, 16'h1234};
        tbl[6] = '{1'b0, 16'h0006, 16'h0000, LAT + 1, 1'b0, 16'h0F0F};
        tbl[7] = '{1'b1, 16'h0003, 16'hDEAD, 0,       1'b1, 16'h0F0F};
        tbl[8] = '{1'b0, 16'h0002, 16'h0000, LAT + 1, 1'b0, 16'h1234};
        tbl[9] = '{1'b0, 16'h0010, 16'h0000, LAT + 1, 1'b0, 16'hBEEF};
        exp_dump = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        ready_pat = 6'b101101;

        en = 1'b1;
        #2;
        chk_quiet("reset");
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].e, tbl[i].rd);
        last_rd = tbl[9].rd;

        for (int k = 0; k < 4; k++) model_access($sformatf("init%0d", k), 1'b1, 16'(2 * k), 16'($urandom));
        for (int i = 0; i < 40; i++)
            model_access($sformatf("rand%0d", i), 1'($urandom), 16'($urandom), 16'($urandom));

        model_access("pre-reset store", 1'b1, 16'h0004, 16'hAAAA);
        en = 1'b1; wr = 1'b1; addr = 16'h0004; wdata = 16'h5555;
        @(posedge clk); #1;
        chk("busy stall", 16'(stall), 16'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid-busy reset");
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = 16'h0000;
        model_access("post-reset load", 1'b0, 16'h0004, 16'h0000);

        for (int k = 0; k < 4; k++) model_access($sformatf("preload%0d", k), 1'b1, 16'(2 * k), exp_dump[k]);
        dump = 1'b1; en = 1'b1; wr = 1'b1; addr = 16'h0000; wdata = 16'hFFFF;
        #4;
        chk("dump entry stall", 16'(stall), 16'd1);
        chk("dump entry done", 16'(done), 16'd0);
        chk("dump entry err", 16'(err), 16'd0);
        @(posedge clk); #1;
        dump = 1'b0; en = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                dump_ready = ready_pat[5 - i];
                #4;
                chk($sformatf("dump%0d valid", i), 16'(dump_valid), 16'd1);
                chk($sformatf("dump%0d stall", i), 16'(stall), 16'd1);
                chk($sformatf("dump%0d addr", i), dump_addr, 16'(2 * k));
                chk($sformatf("dump%0d data", i), dump_data, exp_dump[k]);
                if (dump_ready) k++;
                @(posedge clk); #1;
            end
        end
        dump_ready = 1'b1;
        en = 1'b1; wr = 1'b0; addr = 16'h0002; dump = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) addr = 16'h0005;
            #4;
            chk($sformatf("halt%0d halted", i), 16'(halted), 16'd1);
            chk($sformatf("halt%0d stall", i), 16'(stall), 16'd1);
            chk($sformatf("halt%0d valid", i), 16'(dump_valid), 16'd0);
            chk($sformatf("halt%0d done", i), 16'(done), 16'd0);
            chk($sformatf("halt%0d err", i), 16'(err), 16'd0);
            @(posedge clk); #1;
        end
        en = 1'b0; dump = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
